// File: rtl/cell_open_sequencer_if.sv
// Request/lookup bus between the gameplay FSM, the visibility storage and
// the cell open sequencer.
//   open_req_i/open_x_i/open_y_i : open request from the game FSM
//   busy_o/done_o/result_o       : sequencer status back to the game FSM
//   cell_x_o/cell_y_o            : lookup/write address into cell storage
//   cell_state_i/cell_vis_i      : same-cycle read data at that address
//   vis_we_o                     : write OPEN at the lookup address
// The sequencer connects through the slave modport, the environment through master.
interface cell_open_sequencer_if #(
  parameter int MAX_CELL_WIDTH  = 30,
  parameter int MAX_CELL_HEIGHT = 16
);
  localparam int XW = $clog2(MAX_CELL_WIDTH);
  localparam int YW = $clog2(MAX_CELL_HEIGHT);

  logic          open_req_i;
  logic [XW-1:0] open_x_i;
  logic [YW-1:0] open_y_i;
  logic [XW-1:0] cell_x_o;
  logic [YW-1:0] cell_y_o;
  logic [3:0]    cell_state_i;
  logic [1:0]    cell_vis_i;
  logic          vis_we_o;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    result_o;

  modport master (
    output open_req_i, open_x_i, open_y_i, cell_state_i, cell_vis_i,
    input  cell_x_o, cell_y_o, vis_we_o, busy_o, done_o, result_o
  );

  modport slave (
    input  open_req_i, open_x_i, open_y_i, cell_state_i, cell_vis_i,
    output cell_x_o, cell_y_o, vis_we_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/cell_open_sequencer.sv
// Cell open sequencer for the minesweeper field.
// Reveals a requested cell; when it has no neighbouring mines, flood-reveals
// the connected zero region using a LIFO of coordinates, one visibility
// write per cycle. Reports NOP/SAFE/MINE and keeps the opened-cell count.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   field_width_i     : active columns
//   field_height_i    : active rows
//   mines_count_i     : number of mines in the field
//   clear_i           : zero the opened-cell count (new game)
//   bus               : request/status and cell lookup bus (slave side)
//   opened_count_o    : cells opened since clear/reset
//   win_o             : every non-mine cell has been opened
module cell_open_sequencer #(
  parameter  int MAX_CELL_WIDTH  = 30,
  parameter  int MAX_CELL_HEIGHT = 16,
  localparam int CELL_COUNT      = MAX_CELL_WIDTH * MAX_CELL_HEIGHT,
  localparam int XW              = $clog2(MAX_CELL_WIDTH),
  localparam int YW              = $clog2(MAX_CELL_HEIGHT),
  localparam int CW              = $clog2(CELL_COUNT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [XW-1:0]         field_width_i,
  input  logic [YW-1:0]         field_height_i,
  input  logic [CW-1:0]         mines_count_i,
  input  logic                  clear_i,
  cell_open_sequencer_if.slave  bus,
  output logic [CW-1:0]         opened_count_o,
  output logic                  win_o
);

  localparam logic [1:0] VIS_CLOSE  = 2'd0;
  localparam logic [1:0] RES_NOP    = 2'd0;
  localparam logic [1:0] RES_SAFE   = 2'd1;
  localparam logic [1:0] RES_MINE   = 2'd2;
  localparam logic [3:0] STATE_MINE = 4'd10;
  localparam int         AW         = ((XW + YW) > CW ? (XW + YW) : CW) + 1;

  typedef enum logic [2:0] {IDLE, START, POP, NBR, DONE} fsm_t;

  fsm_t                   state;
  logic [XW-1:0]          cur_x;
  logic [YW-1:0]          cur_y;
  logic [2:0]             nbr_idx;
  logic [CW-1:0]          sp;
  logic [XW+YW-1:0]       stack_mem [CELL_COUNT];
  logic                   busy_q;
  logic                   done_q;
  logic [1:0]             result_q;
  logic [CW-1:0]          count_q;

  logic signed [1:0]      dx;
  logic signed [1:0]      dy;
  logic [XW:0]            nbr_x;
  logic [YW:0]            nbr_y;
  logic                   nbr_in;
  logic                   start_in;
  logic [XW-1:0]          addr_x;
  logic [YW-1:0]          addr_y;
  logic                   we;
  logic                   push;
  logic                   pop;
  logic [AW-1:0]          area;

  // Neighbour offsets, scanned row by row starting top-left.
  function automatic logic signed [1:0] off_x(input logic [2:0] n);
    case (n)
      3'd0, 3'd3, 3'd5: return -2'sd1;
      3'd2, 3'd4, 3'd7: return 2'sd1;
      default:          return 2'sd0;
    endcase
  endfunction

  function automatic logic signed [1:0] off_y(input logic [2:0] n);
    case (n)
      3'd0, 3'd1, 3'd2: return -2'sd1;
      3'd5, 3'd6, 3'd7: return 2'sd1;
      default:          return 2'sd0;
    endcase
  endfunction

  // Neighbour address carries one guard bit: -1 wraps to all ones and the
  // +1 overshoot lands on 2^W, so a single unsigned compare against the
  // field size rejects both edges.
  always_comb begin
    dx     = off_x(nbr_idx);
    dy     = off_y(nbr_idx);
    nbr_x  = {1'b0, cur_x} + {{(XW-1){dx[1]}}, dx};
    nbr_y  = {1'b0, cur_y} + {{(YW-1){dy[1]}}, dy};
    nbr_in = (nbr_x < {1'b0, field_width_i}) && (nbr_y < {1'b0, field_height_i});
    start_in = (cur_x < field_width_i) && (cur_y < field_height_i);
  end

  // Lookup address and write/push decode, same cycle as the storage read.
  always_comb begin
    addr_x = cur_x;
    addr_y = cur_y;
    we     = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    case (state)
      START: begin
        if (start_in && bus.cell_vis_i == VIS_CLOSE) begin
          we   = 1'b1;
          push = (bus.cell_state_i == 4'd0);
        end
      end
      NBR: begin
        addr_x = nbr_x[XW-1:0];
        addr_y = nbr_y[YW-1:0];
        if (nbr_in && bus.cell_vis_i == VIS_CLOSE) begin
          we   = 1'b1;
          push = (bus.cell_state_i == 4'd0);
        end
      end
      POP:     pop = (sp != '0);
      default: ;
    endcase
  end

  // Stack storage holds coordinates only; it needs no reset because the
  // pointer alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) stack_mem[sp] <= {addr_x, addr_y};
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && bus.open_req_i) begin
      cur_x <= bus.open_x_i;
      cur_y <= bus.open_y_i;
    end else if (pop) begin
      {cur_x, cur_y} <= stack_mem[sp - 1'b1];
    end
  end

  // Control FSM; status outputs are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      nbr_idx  <= '0;
      sp       <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= RES_NOP;
    end else begin
      done_q <= 1'b0;
      if (push)     sp <= sp + 1'b1;
      else if (pop) sp <= sp - 1'b1;
      case (state)
        IDLE: begin
          if (bus.open_req_i) begin
            state  <= START;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (!we) begin
            result_q <= RES_NOP;
            done_q   <= 1'b1;
            state    <= DONE;
          end else if (bus.cell_state_i == STATE_MINE) begin
            result_q <= RES_MINE;
            done_q   <= 1'b1;
            state    <= DONE;
          end else if (push) begin
            state <= POP;
          end else begin
            result_q <= RES_SAFE;
            done_q   <= 1'b1;
            state    <= DONE;
          end
        end
        POP: begin
          if (sp == '0) begin
            // A flood only ever touches zero cells and their neighbours.
            result_q <= RES_SAFE;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            nbr_idx <= '0;
            state   <= NBR;
          end
        end
        NBR: begin
          nbr_idx <= nbr_idx + 1'b1;
          if (nbr_idx == 3'd7) state <= POP;
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Opened-cell counter; a clear in the same cycle as a write wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count_q <= '0;
    else if (clear_i) count_q <= '0;
    else if (we)    count_q <= count_q + 1'b1;
  end

  always_comb begin
    area  = AW'(field_width_i) * AW'(field_height_i);
    win_o = (AW'(count_q) == area - AW'(mines_count_i));
  end

  assign bus.cell_x_o    = addr_x;
  assign bus.cell_y_o    = addr_y;
  assign bus.vis_we_o    = we;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
  assign bus.result_o    = result_q;
  assign opened_count_o  = count_q;

endmodule

// File: tb/tb_cell_open_sequencer.sv
module tb_cell_open_sequencer;
  localparam int XW = 5;
  localparam int YW = 4;
  localparam int CW = 9;
  localparam int CELL_COUNT = 480;

  typedef struct {
    int x; int y; int st; int vis; int res; int lat; int wr;
  } vec_t;
  typedef struct { int res; int lat; int wr; } exp_t;

  logic          clk;
  logic          rst;
  logic [XW-1:0] field_width;
  logic [YW-1:0] field_height;
  logic [CW-1:0] mines_count;
  logic          clear;
  logic [CW-1:0] opened_count;
  logic          win;

  cell_open_sequencer_if #(.MAX_CELL_WIDTH(30), .MAX_CELL_HEIGHT(16)) bus ();

  cell_open_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .field_width_i  (field_width),
    .field_height_i (field_height),
    .mines_count_i  (mines_count),
    .clear_i        (clear),
    .bus            (bus),
    .opened_count_o (opened_count),
    .win_o          (win)
  );

  logic [3:0] st_mem  [32][16];
  logic [1:0] vis_mem [32][16];
  int         hits    [32][16];

  assign bus.cell_state_i = st_mem[bus.cell_x_o][bus.cell_y_o];
  assign bus.cell_vis_i   = vis_mem[bus.cell_x_o][bus.cell_y_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bit ovf;
  initial ovf = 1'b0;
  always @(negedge clk) if (int'(dut.sp) > CELL_COUNT) ovf = 1'b1;

  int   n_chk;
  int   n_fail;
  int   fw;
  int   fh;
  int   wr_cnt;
  int   oob_cnt;
  exp_t sbq[$];
  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic setup_field(input int w, input int h, input int fill, input int mines);
    fw = w; fh = h;
    field_width  = XW'(w);
    field_height = YW'(h);
    mines_count  = CW'(mines);
    foreach (st_mem[i, j]) begin
      st_mem[i][j]  = 4'(fill);
      vis_mem[i][j] = 2'd0;
    end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Issue one request, follow it to done_o while modelling the storage,
  // then pop the scoreboard entry and compare.
  task automatic run_req(input int x, input int y, input bit do_clear, input bit junk);
    int k; bit seen; bit pend; int px; int py;
    exp_t e;
    wr_cnt = 0; oob_cnt = 0;
    foreach (hits[i, j]) hits[i][j] = 0;
    @(negedge clk);
    bus.open_req_i = 1'b1;
    bus.open_x_i = XW'(x);
    bus.open_y_i = YW'(y);
    @(posedge clk); #1;
    bus.open_req_i = 1'b0;
    seen = 1'b0; k = 0;
    while (!seen && k < 400) begin
      @(negedge clk); k++;
      if (k == 1) chk("busy_rise", int'(bus.busy_o), 1);
      pend = bus.vis_we_o;
      px = int'(bus.cell_x_o);
      py = int'(bus.cell_y_o);
      if (pend) begin
        wr_cnt++;
        if (px >= fw || py >= fh) oob_cnt++;
        else hits[px][py]++;
      end
      if (do_clear && k == 2) chk("clear_wins", int'(opened_count), 0);
      if (do_clear) clear = (k == 1);
      if (junk) begin
        bus.open_req_i = (k >= 5 && k <= 10);
        bus.open_x_i = '0;
        bus.open_y_i = '0;
      end
      if (bus.done_o) seen = 1'b1;
      @(posedge clk); #1;
      if (pend) vis_mem[px][py] = 2'd1;
    end
    e = sbq.pop_front();
    chk("done_latency", seen ? k : -1, e.lat);
    chk("result", int'(bus.result_o), e.res);
    chk("write_count", wr_cnt, e.wr);
    chk("oob_writes", oob_cnt, 0);
    @(negedge clk);
    chk("busy_fall", int'(bus.busy_o), 0);
    chk("done_pulse", int'(bus.done_o), 0);
  endtask

  initial begin
    exp_t e;
    int bad; int pw; int px; int py;
    n_chk = 0; n_fail = 0;
    rst = 1'b0; clear = 1'b0;
    bus.open_req_i = 1'b0; bus.open_x_i = '0; bus.open_y_i = '0;
    fw = 10; fh = 8;
    field_width = 5'd10; field_height = 4'd8; mines_count = 9'd1;
    foreach (st_mem[i, j]) begin st_mem[i][j] = 4'd3; vis_mem[i][j] = 2'd0; end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy_o), 0);
    chk("rst_done", int'(bus.done_o), 0);
    chk("rst_we", int'(bus.vis_we_o), 0);
    chk("rst_result", int'(bus.result_o), 0);
    chk("rst_count", int'(opened_count), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single-cell vectors on a 10x8 field
    vecs[0] = '{x:5, y:5, st:3,  vis:0, res:1, lat:2, wr:1};
    vecs[1] = '{x:0, y:0, st:10, vis:0, res:2, lat:2, wr:1};
    vecs[2] = '{x:2, y:2, st:3,  vis:2, res:0, lat:2, wr:0};
    vecs[3] = '{x:3, y:3, st:3,  vis:1, res:0, lat:2, wr:0};
    vecs[4] = '{x:10, y:0, st:3, vis:0, res:0, lat:2, wr:0};
    vecs[5] = '{x:9, y:7, st:8,  vis:0, res:1, lat:2, wr:1};
    vecs[6] = '{x:0, y:8, st:3,  vis:0, res:0, lat:2, wr:0};
    for (int v = 0; v < 7; v++) begin
      setup_field(10, 8, 3, 1);
      st_mem[vecs[v].x][vecs[v].y]  = 4'(vecs[v].st);
      vis_mem[vecs[v].x][vecs[v].y] = 2'(vecs[v].vis);
      e = '{res: vecs[v].res, lat: vecs[v].lat, wr: vecs[v].wr};
      sbq.push_back(e);
      run_req(vecs[v].x, vecs[v].y, 1'b0, 1'b0);
      chk("vec_count", int'(opened_count), vecs[v].wr);
      chk("vec_win", int'(win), 0);
    end

    // 4x3 all-zero flood
    setup_field(4, 3, 0, 0);
    e = '{res: 1, lat: 111, wr: 12};
    sbq.push_back(e);
    run_req(0, 0, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 3; j++) if (hits[i][j] != 1) bad++;
    chk("each_once", bad, 0);
    chk("flood_count", int'(opened_count), 12);
    chk("flood_win", int'(win), 1);

    // Flags inside the zero region, with a request while busy
    setup_field(4, 3, 0, 0);
    vis_mem[2][1] = 2'd2;
    vis_mem[3][2] = 2'd2;
    e = '{res: 1, lat: 93, wr: 10};
    sbq.push_back(e);
    run_req(0, 0, 1'b0, 1'b1);
    chk("flag_hits", hits[2][1] + hits[3][2], 0);
    chk("flag_kept", int'(vis_mem[2][1]) + int'(vis_mem[3][2]), 4);
    chk("flag_count", int'(opened_count), 10);
    chk("flag_win", int'(win), 0);
    repeat (3) @(negedge clk);
    chk("junk_dropped", int'(bus.busy_o), 0);

    // Clear concurrent with the first write of a flood
    setup_field(4, 3, 0, 0);
    e = '{res: 1, lat: 111, wr: 12};
    sbq.push_back(e);
    run_req(0, 0, 1'b1, 1'b0);
    chk("clear_count", int'(opened_count), 11);

    // Reset mid-flood with a request pending
    setup_field(4, 3, 0, 0);
    @(negedge clk);
    bus.open_req_i = 1'b1; bus.open_x_i = '0; bus.open_y_i = '0;
    @(posedge clk); #1;
    bus.open_req_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      pw = int'(bus.vis_we_o); px = int'(bus.cell_x_o); py = int'(bus.cell_y_o);
      @(posedge clk); #1;
      if (pw != 0) vis_mem[px][py] = 2'd1;
    end
    @(negedge clk);
    bus.open_req_i = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy_o), 0);
    chk("arst_we", int'(bus.vis_we_o), 0);
    chk("arst_count", int'(opened_count), 0);
    chk("arst_result", int'(bus.result_o), 0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bad += int'(bus.vis_we_o) + int'(bus.busy_o);
    end
    chk("arst_quiet", bad, 0);
    bus.open_req_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", int'(bus.busy_o), 0);

    chk("stack_bound", int'(ovf), 0);
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
